// File: rtl/bp_be_stride_prefetch_table.sv
// Multi-stream stride predictor: learns a signed stride per load PC and, once
// confident, issues a page-bounded run of lookahead prefetches on one valid/ready port.
module bp_be_stride_prefetch_table
    #(parameter int vaddr_width_p  = 39
    , parameter int entries_p      = 4
    , parameter int stride_width_p = 12
    , parameter int conf_width_p   = 2
    , parameter int conf_thresh_p  = 2
    , parameter int lookahead_p    = 4
    )
    (input  logic                          clk_i
    , input  logic                          reset_n_i
    , input  logic                          obs_v_i
    , input  logic [vaddr_width_p-1:0]      obs_pc_i
    , input  logic [vaddr_width_p-1:0]      obs_addr_i
    , input  logic                          flush_i
    , output logic                          pf_v_o
    , output logic [vaddr_width_p-1:0]      pf_addr_o
    , output logic [$clog2(entries_p)-1:0]  pf_entry_o
    , input  logic                          pf_ready_and_i
    , output logic                          busy_o
    );

    localparam int idx_w_lp    = $clog2(entries_p);
    localparam int page_lsb_lp = 12;
    localparam logic [conf_width_p-1:0] conf_thresh_lp = conf_width_p'(conf_thresh_p);
    localparam logic [7:0]              lookahead_lp   = 8'(lookahead_p);
    localparam logic [idx_w_lp-1:0]     last_idx_lp    = idx_w_lp'(entries_p-1);

    typedef logic [vaddr_width_p-1:0]         addr_t;
    typedef logic signed [stride_width_p-1:0] stride_t;

    function automatic addr_t sext_stride(input stride_t s);
        return {{(vaddr_width_p-stride_width_p){s[stride_width_p-1]}}, s};
    endfunction

    // A delta only becomes a stride when it is representable; anything wider reads as zero.
    function automatic stride_t fit_stride(input addr_t delta);
        logic [vaddr_width_p-stride_width_p:0] upper;
        upper = delta[vaddr_width_p-1:stride_width_p-1];
        return (&upper || !(|upper)) ? stride_t'(delta[stride_width_p-1:0]) : '0;
    endfunction

    function automatic logic [conf_width_p-1:0] conf_sat_inc(input logic [conf_width_p-1:0] c);
        return (&c) ? c : c + conf_width_p'(1);
    endfunction

    logic [entries_p-1:0]    v_r;
    addr_t                   tag_r       [entries_p];
    addr_t                   last_addr_r [entries_p];
    stride_t                 stride_r    [entries_p];
    logic [conf_width_p-1:0] conf_r      [entries_p];
    addr_t                   next_addr_r [entries_p];
    logic [7:0]              remaining_r [entries_p];
    logic [idx_w_lp-1:0]     victim_ptr_r;
    logic [idx_w_lp-1:0]     arb_ptr_r;

    logic [entries_p-1:0]    hit_vec;
    logic [entries_p-1:0]    req_vec;
    logic                    hit;
    logic                    any_inv;
    logic                    obs_act;
    logic [idx_w_lp-1:0]     hit_idx;
    logic [idx_w_lp-1:0]     inv_idx;
    logic [idx_w_lp-1:0]     alloc_idx;
    addr_t                   delta;
    stride_t                 new_stride;
    logic                    same_stride;
    logic [conf_width_p-1:0] conf_upd;
    logic                    trig;

    // observation lookup: tag match, stride fit and confidence update
    always_comb begin
        hit_vec = '0;
        req_vec = '0;
        hit_idx = '0;
        inv_idx = '0;
        any_inv = 1'b0;
        for (int i = entries_p-1; i >= 0; i--) begin
            hit_vec[i] = v_r[i] && (tag_r[i] == obs_pc_i);
            req_vec[i] = (remaining_r[i] != 8'd0);
            if (hit_vec[i]) hit_idx = idx_w_lp'(i);
            if (!v_r[i]) begin
                inv_idx = idx_w_lp'(i);
                any_inv = 1'b1;
            end
        end
        hit         = |hit_vec;
        obs_act     = obs_v_i && !flush_i;
        alloc_idx   = any_inv ? inv_idx : victim_ptr_r;
        delta       = obs_addr_i - last_addr_r[hit_idx];
        new_stride  = fit_stride(delta);
        same_stride = (new_stride == stride_r[hit_idx]) && (stride_r[hit_idx] != '0);
        conf_upd    = same_stride ? conf_sat_inc(conf_r[hit_idx]) : '0;
        trig        = (conf_upd >= conf_thresh_lp);
    end

    logic                gnt_found_p0;
    logic                gnt_vld_p0;
    logic                page_ok_p0;
    logic [idx_w_lp-1:0] gnt_idx_p0;
    logic [idx_w_lp-1:0] cand_p0;
    int                  scan_p0;

    // grant stage: round-robin starting after the last granted entry
    always_comb begin
        gnt_found_p0 = 1'b0;
        gnt_idx_p0   = '0;
        cand_p0      = '0;
        scan_p0      = 0;
        for (int k = 1; k <= entries_p; k++) begin
            scan_p0 = (int'(arb_ptr_r) + k) % entries_p;
            cand_p0 = idx_w_lp'(scan_p0);
            if (!gnt_found_p0 && req_vec[cand_p0]) begin
                gnt_found_p0 = 1'b1;
                gnt_idx_p0   = cand_p0;
            end
        end
        gnt_vld_p0 = gnt_found_p0 && (!pf_v_o || pf_ready_and_i) && !flush_i;
        page_ok_p0 = (next_addr_r[gnt_idx_p0][vaddr_width_p-1:page_lsb_lp]
                      == last_addr_r[gnt_idx_p0][vaddr_width_p-1:page_lsb_lp]);
    end

    assign busy_o = pf_v_o || (|req_vec);

    // output register and per-entry control; observation writes land last so they win
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_r <= '0;
            for (int i = 0; i < entries_p; i++) begin
                conf_r[i]      <= '0;
                remaining_r[i] <= 8'd0;
            end
            victim_ptr_r <= '0;
            arb_ptr_r    <= '0;
            pf_v_o       <= 1'b0;
            pf_addr_o    <= '0;
            pf_entry_o   <= '0;
        end else if (flush_i) begin
            v_r <= '0;
            for (int i = 0; i < entries_p; i++) begin
                conf_r[i]      <= '0;
                remaining_r[i] <= 8'd0;
            end
            victim_ptr_r <= '0;
            arb_ptr_r    <= '0;
            pf_v_o       <= 1'b0;
        end else begin
            if (pf_v_o && pf_ready_and_i) pf_v_o <= 1'b0;
            if (gnt_vld_p0) begin
                arb_ptr_r <= gnt_idx_p0;
                if (page_ok_p0) begin
                    pf_v_o                  <= 1'b1;
                    pf_addr_o               <= next_addr_r[gnt_idx_p0];
                    pf_entry_o              <= gnt_idx_p0;
                    remaining_r[gnt_idx_p0] <= remaining_r[gnt_idx_p0] - 8'd1;
                end else begin
                    remaining_r[gnt_idx_p0] <= 8'd0;
                end
            end
            if (obs_act) begin
                if (hit) begin
                    conf_r[hit_idx] <= conf_upd;
                    if (trig)              remaining_r[hit_idx] <= lookahead_lp;
                    else if (!same_stride) remaining_r[hit_idx] <= 8'd0;
                end else begin
                    v_r[alloc_idx]         <= 1'b1;
                    conf_r[alloc_idx]      <= '0;
                    remaining_r[alloc_idx] <= 8'd0;
                    if (!any_inv)
                        victim_ptr_r <= (victim_ptr_r == last_idx_lp) ? '0
                                        : victim_ptr_r + idx_w_lp'(1);
                end
            end
        end
    end

    // per-entry address/stride datapath
    always_ff @(posedge clk_i) begin
        if (gnt_vld_p0 && page_ok_p0)
            next_addr_r[gnt_idx_p0] <= next_addr_r[gnt_idx_p0] + sext_stride(stride_r[gnt_idx_p0]);
        if (obs_act) begin
            if (hit) begin
                stride_r[hit_idx]    <= new_stride;
                last_addr_r[hit_idx] <= obs_addr_i;
                if (trig) next_addr_r[hit_idx] <= obs_addr_i + sext_stride(new_stride);
            end else begin
                tag_r[alloc_idx]       <= obs_pc_i;
                last_addr_r[alloc_idx] <= obs_addr_i;
                stride_r[alloc_idx]    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bp_be_stride_prefetch_table.sv
// Bench for bp_be_stride_prefetch_table: per-cycle vector table checked through a
// scoreboard queue, plus a hand-written asynchronous-reset sequence.
module tb_bp_be_stride_prefetch_table;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        obs_v;
    logic [38:0] obs_pc;
    logic [38:0] obs_addr;
    logic        flush;
    logic        pf_v;
    logic [38:0] pf_addr;
    logic [1:0]  pf_entry;
    logic        ready;
    logic        busy;

    bp_be_stride_prefetch_table dut
        (.clk_i(clk), .reset_n_i(reset_n), .obs_v_i(obs_v), .obs_pc_i(obs_pc),
         .obs_addr_i(obs_addr), .flush_i(flush), .pf_v_o(pf_v), .pf_addr_o(pf_addr),
         .pf_entry_o(pf_entry), .pf_ready_and_i(ready), .busy_o(busy));

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        obs_v;
        logic [38:0] pc;
        logic [38:0] addr;
        logic        flush;
        logic        ready;
        logic        e_v;
        logic [38:0] e_addr;
        logic [1:0]  e_entry;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    vec_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    logic sb_on = 1'b0;

    task automatic g(input logic ov, input logic [38:0] pc, input logic [38:0] a,
                     input logic fl, input logic rd, input logic ev,
                     input logic [38:0] ea, input logic [1:0] ee, input logic eb);
        vec_t t;
        t.id = vecs.size(); t.obs_v = ov; t.pc = pc; t.addr = a; t.flush = fl; t.ready = rd;
        t.e_v = ev; t.e_addr = ea; t.e_entry = ee; t.e_busy = eb;
        vecs.push_back(t);
    endtask

    task automatic o(input logic [38:0] pc, input logic [38:0] a, input logic ev,
                     input logic [38:0] ea, input logic [1:0] ee, input logic eb);
        g(1'b1, pc, a, 1'b0, 1'b1, ev, ea, ee, eb);
    endtask

    task automatic n(input logic ev, input logic [38:0] ea, input logic [1:0] ee, input logic eb);
        g(1'b0, '0, '0, 1'b0, 1'b1, ev, ea, ee, eb);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic build();
        // training, lookahead 4 on PC 0x100 (entry 0)
        o('h100, 'h1000, 0, 0, 0, 0);
        o('h100, 'h1040, 0, 0, 0, 0);
        o('h100, 'h1080, 0, 0, 0, 0);
        o('h100, 'h10C0, 0, 0, 0, 0);
        n(0, 0, 0, 1);
        n(1, 'h1100, 0, 1);
        n(1, 'h1140, 0, 1);
        n(1, 'h1180, 0, 1);
        n(1, 'h11C0, 0, 1);
        n(0, 0, 0, 0);
        // page bound on PC 0x200 (entry 1), stride 0x400
        o('h200, 'h1C00, 0, 0, 0, 0);
        o('h200, 'h2000, 0, 0, 0, 0);
        o('h200, 'h2400, 0, 0, 0, 0);
        o('h200, 'h2800, 0, 0, 0, 0);
        n(0, 0, 0, 1);
        n(1, 'h2C00, 1, 1);
        n(0, 0, 0, 0);
        // backpressure for 10 cycles, then a mismatching observation on the issuing entry
        g(1, 'h100, 'h1100, 0, 0, 0, 0, 0, 0);
        g(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) g(0, 0, 0, 0, 0, 1, 'h1140, 0, 1);
        g(1, 'h100, 'h1108, 0, 1, 1, 'h1140, 0, 1);
        n(1, 'h1180, 0, 1);
        // retrain at stride 8, then flush with a pending request and a simultaneous observation
        o('h100, 'h1110, 0, 0, 0, 0);
        o('h100, 'h1118, 0, 0, 0, 0);
        n(0, 0, 0, 1);
        g(1, 'h700, 'h7000, 1, 0, 1, 'h1120, 0, 1);
        n(0, 0, 0, 0);
        o('h700, 'h7040, 0, 0, 0, 0);
        o('h700, 'h7080, 0, 0, 0, 0);
        o('h700, 'h70C0, 0, 0, 0, 0);
        n(0, 0, 0, 0);
        n(0, 0, 0, 0);
        // five PCs in four entries, then two interleaved streams on entries 1 and 2
        o('h800, 'h8000, 0, 0, 0, 0);
        o('h900, 'h9000, 0, 0, 0, 0);
        o('hA00, 'hA000, 0, 0, 0, 0);
        o('hB00, 'hB000, 0, 0, 0, 0);
        o('h800, 'h8040, 0, 0, 0, 0);
        o('h900, 'h9080, 0, 0, 0, 0);
        o('h800, 'h8080, 0, 0, 0, 0);
        o('h900, 'h9100, 0, 0, 0, 0);
        o('h800, 'h80C0, 0, 0, 0, 0);
        o('h900, 'h9180, 0, 0, 0, 1);
        n(1, 'h8100, 1, 1);
        n(1, 'h9200, 2, 1);
        n(1, 'h8140, 1, 1);
        n(1, 'h9280, 2, 1);
        n(1, 'h8180, 1, 1);
        n(1, 'h9300, 2, 1);
        n(1, 'h81C0, 1, 1);
        n(1, 'h9380, 2, 1);
        n(0, 0, 0, 0);
        // PC 0xB00 must live in entry 0 after the eviction
        o('hB00, 'hB010, 0, 0, 0, 0);
        o('hB00, 'hB020, 0, 0, 0, 0);
        o('hB00, 'hB030, 0, 0, 0, 0);
        n(0, 0, 0, 1);
        n(1, 'hB040, 0, 1);
        n(1, 'hB050, 0, 1);
        n(1, 'hB060, 0, 1);
        n(1, 'hB070, 0, 1);
        // victim pointer now 1: 0xC00 evicts PC 0x800, so 0x800 re-allocates cold
        o('hC00, 'hC000, 0, 0, 0, 0);
        o('h800, 'h8100, 0, 0, 0, 0);
        n(0, 0, 0, 0);
        n(0, 0, 0, 0);
        // deltas of 0x10040 overflow a 12-bit stride and never train
        o('hD00, 'h20000, 0, 0, 0, 0);
        o('hD00, 'h30040, 0, 0, 0, 0);
        o('hD00, 'h40080, 0, 0, 0, 0);
        o('hD00, 'h500C0, 0, 0, 0, 0);
        n(0, 0, 0, 0);
        n(0, 0, 0, 0);
        // negative stride -0x40: one prefetch, then the run crosses into page 5
        o('hE00, 'h6100, 0, 0, 0, 0);
        o('hE00, 'h60C0, 0, 0, 0, 0);
        o('hE00, 'h6080, 0, 0, 0, 0);
        o('hE00, 'h6040, 0, 0, 0, 0);
        n(0, 0, 0, 1);
        n(1, 'h6000, 0, 1);
        n(0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (sb_on && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if (pf_v !== mon_e.e_v || busy !== mon_e.e_busy ||
                (mon_e.e_v && (pf_addr !== mon_e.e_addr || pf_entry !== mon_e.e_entry))) begin
                n_err++;
                $display("FAIL vec%0d: got v=%b addr=%h entry=%0d busy=%b, required v=%b addr=%h entry=%0d busy=%b",
                         mon_e.id, pf_v, pf_addr, pf_entry, busy,
                         mon_e.e_v, mon_e.e_addr, mon_e.e_entry, mon_e.e_busy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required run to complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1;
        obs_v = 1'b0; obs_pc = '0; obs_addr = '0; flush = 1'b0; ready = 1'b1;
        build();
        #1 reset_n = 1'b0;
        #2;
        chk("reset pf_v", 64'(pf_v), 0);
        chk("reset pf_addr", 64'(pf_addr), 0);
        chk("reset pf_entry", 64'(pf_entry), 0);
        chk("reset busy", 64'(busy), 0);
        #19 reset_n = 1'b1;

        sb_on = 1'b1;
        foreach (vecs[k]) begin
            @(posedge clk); #1;
            obs_v = vecs[k].obs_v; obs_pc = vecs[k].pc; obs_addr = vecs[k].addr;
            flush = vecs[k].flush; ready = vecs[k].ready;
            exp_q.push_back(vecs[k]);
        end
        @(posedge clk); #1;
        obs_v = 1'b0; flush = 1'b0; ready = 1'b1;
        sb_on = 1'b0;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d vectors left, required 0", exp_q.size());
        end

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            obs_v = 1'b1; obs_pc = 39'h100; obs_addr = 39'h1000 + 39'(i * 'h40);
        end
        @(posedge clk); #1; obs_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrun pf_v before reset", 64'(pf_v), 1);
        chk("midrun pf_addr before reset", 64'(pf_addr), 'h1100);
        #2 reset_n = 1'b0;
        #1;
        chk("midrun pf_v in reset", 64'(pf_v), 0);
        chk("midrun pf_addr in reset", 64'(pf_addr), 0);
        chk("midrun busy in reset", 64'(busy), 0);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            obs_v = 1'b1; obs_pc = 39'h100; obs_addr = 39'h1100 + 39'(i * 'h40);
        end
        @(posedge clk); #1; obs_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("retrain pf_v", 64'(pf_v), 0);
            chk("retrain busy", 64'(busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
